// File: rtl/vid_pkg.sv
// Shared types and helpers for the synthetic video source.
package vid_pkg;

  localparam int PIX_W = 12;

  typedef enum logic [1:0] {RAMP_H, RAMP_V, CHECKER, LFSR} vid_mode_t;
  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} vid_gen_state_t;

  function automatic logic [PIX_W-1:0] lfsr_next(input logic [PIX_W-1:0] s);
    return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
  endfunction

endpackage

// File: rtl/vid_lfsr12.sv
// 12-bit Fibonacci LFSR; seed restarts at 12'h001 and wins over advance.
module vid_lfsr12
  import vid_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             seed,
  input  logic             advance,
  output logic [PIX_W-1:0] value
);

  localparam logic [PIX_W-1:0] SEED_VAL = 12'h001;

  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= SEED_VAL;
    end else if (seed) begin
      value <= SEED_VAL;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/vid_pattern_gen.sv
// Camera-link style test-pattern source: pixel outputs load on the last divider clock, so they are stable for a full pixel period.
// state | meaning: IDLE waiting for enable | VBLANK blank lines | ACTIVE visible x | HBLANK line tail
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 320,
  parameter int H_BLANK  = 16,
  parameter int V_ACTIVE = 240,
  parameter int V_BLANK  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic [11:0] vid_pixel,
  output logic        vid_pixsync,
  output logic        vid_hblank,
  output logic        vid_vblank,
  output logic        vid_visible,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int DIV_W = $clog2(PIX_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PIX_DIV - 1);
  localparam logic [15:0]      H_TOT_LAST = 16'(H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0]      H_ACT_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0]      H_BLK_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0]      V_ACT_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0]      V_BLK_LAST = 16'(V_BLANK - 1);

  vid_gen_state_t   state, state_n;
  vid_mode_t        mode_q;
  logic [DIV_W-1:0] div;
  logic [15:0]      x, y, x_n, y_n;
  logic             pix_end, start, frame_done, lfsr_adv;
  logic [PIX_W-1:0] lfsr_val, pixel_n;
  logic             hblank_n, vblank_n, visible_n;

  assign pix_end     = (div == DIV_LAST);
  assign vid_pixsync = pix_end;
  // A frame always begins from IDLE on a boundary clock, which also covers back-to-back frames.
  assign start       = rst && (state == IDLE) && (div == '0) && enable;
  assign frame_start = start;
  assign lfsr_adv    = pix_end && visible_n;

  vid_lfsr12 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .seed    (start),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      div         <= '0;
      x           <= '0;
      y           <= '0;
      mode_q      <= RAMP_H;
      frame_count <= '0;
      vid_pixel   <= '0;
      vid_hblank  <= 1'b0;
      vid_vblank  <= 1'b1;
      vid_visible <= 1'b0;
    end else begin
      div   <= pix_end ? '0 : div + 1'b1;
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      if (start) mode_q <= vid_mode_t'(mode);
      if (pix_end) begin
        vid_pixel   <= pixel_n;
        vid_hblank  <= hblank_n;
        vid_vblank  <= vblank_n;
        vid_visible <= visible_n;
        if (frame_done) frame_count <= frame_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = VBLANK;
          x_n     = '0;
          y_n     = '0;
        end
      end
      VBLANK: begin
        if (pix_end) begin
          if (x == H_TOT_LAST) begin
            x_n = '0;
            if (y == V_BLK_LAST) begin
              state_n = ACTIVE;
              y_n     = '0;
            end else begin
              y_n = y + 1'b1;
            end
          end else begin
            x_n = x + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (pix_end) begin
          if (x == H_ACT_LAST) begin
            state_n = HBLANK;
            x_n     = '0;
          end else begin
            x_n = x + 1'b1;
          end
        end
      end
      HBLANK: begin
        if (pix_end) begin
          if (x == H_BLK_LAST) begin
            x_n = '0;
            if (y == V_ACT_LAST) begin
              state_n    = IDLE;
              y_n        = '0;
              frame_done = 1'b1;
            end else begin
              state_n = ACTIVE;
              y_n     = y + 1'b1;
            end
          end else begin
            x_n = x + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    vblank_n  = (state_n == IDLE) || (state_n == VBLANK);
    hblank_n  = (state_n == HBLANK);
    visible_n = (state_n == ACTIVE);
    pixel_n   = '0;
    if (visible_n) begin
      case (mode_q)
        RAMP_H:  pixel_n = {x_n[8:0], 3'b000};
        RAMP_V:  pixel_n = {y_n[7:0], 4'b0000};
        CHECKER: pixel_n = (x_n[3] ^ y_n[3]) ? 12'hFFF : 12'h000;
        default: pixel_n = lfsr_val;
      endcase
    end
  end

endmodule
